// File: rtl/disp_pkg.sv
// Shared types and helpers for the multiplexed display blocks.
package disp_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BLANK_CODE = 4'hF;

  // Index width for an n-entry range; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count of each period.
module scan_tick_gen
  import disp_pkg::*;
#(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = idx_w(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == CntMax);
  assign cnt_d = tick ? '0 : cnt_q + CntW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multi-digit 7-segment scan controller with frame-aligned value updates.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  ready,
  output logic [3:0]            bcd_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_an,
  output logic                  frame_start
);

  localparam int unsigned IdxW = idx_w(DIGITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  logic tick;
  logic wrap;
  logic accept;

  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    frame_wrap_q;
  bcd_t [DIGITS-1:0]       pend_q, pend_d;
  bcd_t [DIGITS-1:0]       shadow_q, shadow_d;
  logic [DIGITS-1:0]       pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]       shadow_dp_q, shadow_dp_d;
  logic                    pending_q, pending_d;
  logic                    ready_q, ready_d;
  bcd_t                    bcd_q, bcd_d;
  logic                    dp_q;
  logic [DIGITS-1:0]       an_q;
  logic                    fs_q;

  scan_tick_gen #(
    .DIV (SCAN_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign wrap   = tick && (idx_q == LastIdx);
  assign accept = load && ready_q;

  always_comb begin
    idx_d       = idx_q;
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pending_d   = pending_q;
    ready_d     = ready_q;

    if (tick) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
    end

    // Uses pre-edge pending, so a capture on the wrap edge waits a full frame.
    if (wrap && pending_q) begin
      shadow_d    = pend_q;
      shadow_dp_d = pend_dp_q;
      pending_d   = 1'b0;
    end

    // ready reopens one cycle after the wrap, together with frame_start.
    if (accept) begin
      pend_d    = value;
      pend_dp_d = dp_in;
      pending_d = 1'b1;
      ready_d   = 1'b0;
    end else if (!pending_q) begin
      ready_d = 1'b1;
    end
  end

`ifdef SEG_SCAN_LZB_EN
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    bcd_d      = shadow_q[idx_q];
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (shadow_q[i] == 4'h0);
      if ((idx_q == IdxW'(i)) && upper_zero) begin
        bcd_d = BLANK_CODE;
      end
    end
  end
`else
  assign bcd_d = shadow_q[idx_q];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      frame_wrap_q <= 1'b0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      ready_q      <= 1'b1;
      bcd_q        <= '0;
      dp_q         <= 1'b0;
      an_q         <= ~DIGITS'(1);
      fs_q         <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      frame_wrap_q <= wrap;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      ready_q      <= ready_d;
      bcd_q        <= bcd_d;
      dp_q         <= shadow_dp_q[idx_q];
      an_q         <= ~(DIGITS'(1) << idx_q);
      fs_q         <= frame_wrap_q;
    end
  end

  assign ready       = ready_q;
  assign bcd_out     = bcd_q;
  assign dp_out      = dp_q;
  assign dig_an      = an_q;
  assign frame_start = fs_q;

endmodule
